// File: rtl/alu_pipe_reg_if.sv
// Handshake bundle for alu_pipe_reg: operand input channel, result output
// channel with flags, and the completed-result counter.
interface alu_pipe_reg_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [3:0]   aluControl;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] y;
  logic         negativo;
  logic         cero;
  logic         acarreo;
  logic         desbordamiento;
  logic [15:0]  op_count;

  modport master (
    output in_valid, a, b, aluControl, out_ready,
    input  in_ready, out_valid, y, negativo, cero, acarreo, desbordamiento, op_count
  );

  modport slave (
    input  in_valid, a, b, aluControl, out_ready,
    output in_ready, out_valid, y, negativo, cero, acarreo, desbordamiento, op_count
  );
endinterface

// File: rtl/alu_pipe_reg.sv
// Pipelined ALU with valid/ready flow control: operand register, ALU feeding the
// result register, optional delay stages; every stage buffers one result.
module alu_pipe_reg #(
  parameter int N      = 32,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  alu_pipe_reg_if.slave bus
);
  localparam int SHW = $clog2(N);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9
  } op_e;

  typedef struct packed {
    logic [N-1:0] y;
    logic         neg;
    logic         zero;
    logic         carry;
    logic         ovf;
  } res_t;

  logic [STAGES:1] v;
  logic [STAGES:1] adv;
  logic            s1_open;
  logic            in_ready_c;
  logic            in_xfer;

  logic [N-1:0] a_r;
  logic [N-1:0] b_r;
  op_e          op_r;
  res_t         alu_res;
  res_t         res [2:STAGES];
  logic [15:0]  op_count_r;

  // Walk from the output back: a stage moves when full and the stage after it
  // is empty or moving, so a full pipe still passes one result per cycle.
  always_comb begin
    logic go;
    adv = '0;
    go  = bus.out_ready;
    for (int k = STAGES; k >= 1; k--) begin
      adv[k] = v[k] & go;
      go     = !v[k] | adv[k];
    end
    s1_open = go;
  end

  assign in_ready_c = !reset & s1_open;
  assign in_xfer    = bus.in_valid & in_ready_c;

  // NOTE: operand registers carry no reset; their contents are only consumed
  // behind a valid bit, so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      a_r  <= bus.a;
      b_r  <= bus.b;
      op_r <= op_e'(bus.aluControl);
    end
  end

  // Single adder shared by ADD and SUB; SUB is a + ~b + 1.
  always_comb begin
    logic         sub;
    logic [N-1:0] bx;
    logic [N:0]   sum;
    logic [SHW-1:0] sh;
    sub = (op_r == OP_SUB);
    bx  = sub ? ~b_r : b_r;
    sum = {1'b0, a_r} + {1'b0, bx} + {{N{1'b0}}, sub};
    sh  = b_r[SHW-1:0];
    alu_res = '0;
    case (op_r)
      OP_ADD, OP_SUB: begin
        alu_res.y     = sum[N-1:0];
        alu_res.carry = sum[N];
        alu_res.ovf   = (a_r[N-1] == bx[N-1]) & (sum[N-1] != a_r[N-1]);
      end
      OP_AND:  alu_res.y = a_r & b_r;
      OP_OR:   alu_res.y = a_r | b_r;
      OP_XOR:  alu_res.y = a_r ^ b_r;
      OP_SLL:  alu_res.y = a_r << sh;
      OP_SRL:  alu_res.y = a_r >> sh;
      OP_SRA:  alu_res.y = $signed(a_r) >>> sh;
      OP_SLT:  alu_res.y = {{(N-1){1'b0}}, ($signed(a_r) < $signed(b_r))};
      OP_SLTU: alu_res.y = {{(N-1){1'b0}}, (a_r < b_r)};
      default: alu_res.y = '0;
    endcase
    alu_res.neg  = alu_res.y[N-1];
    alu_res.zero = (alu_res.y == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v          <= '0;
      op_count_r <= '0;
      for (int k = 2; k <= STAGES; k++) res[k] <= '0;
    end else begin
      if (s1_open) v[1] <= in_xfer;
      for (int k = 2; k <= STAGES; k++) begin
        if (!v[k] | adv[k]) v[k] <= adv[k-1];
      end
      if (adv[1]) res[2] <= alu_res;
      for (int k = 3; k <= STAGES; k++) begin
        if (adv[k-1]) res[k] <= res[k-1];
      end
      if (adv[STAGES]) op_count_r <= op_count_r + 16'd1;
    end
  end

  assign bus.in_ready       = in_ready_c;
  assign bus.out_valid      = v[STAGES];
  assign bus.y              = res[STAGES].y;
  assign bus.negativo       = res[STAGES].neg;
  assign bus.cero           = res[STAGES].zero;
  assign bus.acarreo        = res[STAGES].carry;
  assign bus.desbordamiento = res[STAGES].ovf;
  assign bus.op_count       = op_count_r;
endmodule

// File: tb/tb_alu_pipe_reg.sv
// Directed bench for alu_pipe_reg (N=32, STAGES=2): latency, opcodes and flags,
// backpressure buffering, mid-flight reset and op_count wrap.
module tb_alu_pipe_reg;
  logic clk = 1'b0;
  logic reset;
  int   total  = 0;
  int   passed = 0;

  alu_pipe_reg_if #(.N(32)) bus ();

  alu_pipe_reg #(.N(32), .STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    else passed++;
  endtask

  function automatic logic [3:0] flags();
    return {bus.negativo, bus.cero, bus.acarreo, bus.desbordamiento};
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid   = 1'b1;
    bus.aluControl = op;
    bus.a          = a;
    bus.b          = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One operation with out_ready held high: result due two cycles after transfer.
  // ef = {negativo, cero, acarreo, desbordamiento}
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ey, input logic [3:0] ef);
    @(negedge clk);
    drive(op, a, b);
    bus.out_ready = 1'b1;
    #1 check({tag, "_rdy"}, bus.in_ready, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 check({tag, "_early"}, bus.out_valid, 1'b0);
    @(negedge clk);
    #1;
    check({tag, "_vld"}, bus.out_valid, 1'b1);
    check({tag, "_y"}, bus.y, ey);
    check({tag, "_flags"}, flags(), ef);
  endtask

  initial begin
    int accepted;
    int seen;
    int errs;
    int vcount;

    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.aluControl = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b1;
    #1;
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_y", bus.y, 32'h0);
    check("rst_flags", flags(), 4'b0000);
    check("rst_op_count", bus.op_count, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    #1 check("first_cycle_ready", bus.in_ready, 1'b1);

    // Backpressure: two buffered, third held, then drained in order
    do_reset();
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(4'd0, 32'd1, 32'd1);
    #1 check("bp_rdy1", bus.in_ready, 1'b1);
    @(negedge clk);
    drive(4'd0, 32'd2, 32'd2);
    #1 check("bp_rdy2", bus.in_ready, 1'b1);
    @(negedge clk);
    drive(4'd0, 32'd3, 32'd3);
    #1;
    check("bp_full_rdy", bus.in_ready, 1'b0);
    check("bp_full_vld", bus.out_valid, 1'b1);
    check("bp_full_y", bus.y, 32'd2);
    @(negedge clk);
    #1;
    check("bp_stall_rdy", bus.in_ready, 1'b0);
    check("bp_stall_y", bus.y, 32'd2);
    check("bp_stall_flags", flags(), 4'b0000);
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    check("bp_pass_rdy", bus.in_ready, 1'b1);
    check("bp_pass_y", bus.y, 32'd2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("bp_y2_vld", bus.out_valid, 1'b1);
    check("bp_y2", bus.y, 32'd4);
    @(negedge clk);
    #1;
    check("bp_y3_vld", bus.out_valid, 1'b1);
    check("bp_y3", bus.y, 32'd6);
    @(negedge clk);
    #1;
    check("bp_drained", bus.out_valid, 1'b0);
    check("bp_op_count", bus.op_count, 16'd3);

    // Opcodes and flags                       n z c v
    run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b0110);
    run_op("sub_ovf", 4'd1, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 4'b0011);
    run_op("sra", 4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000, 4'b1000);
    run_op("sll_mask", 4'd5, 32'h1, 32'd33, 32'h2, 4'b0000);
    run_op("sub_borrow", 4'd1, 32'h1, 32'h2, 32'hFFFF_FFFF, 4'b1000);
    run_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b1001);
    run_op("and", 4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b1000);
    run_op("or", 4'd3, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 4'b0000);
    run_op("xor", 4'd4, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 4'b0000);
    run_op("srl_mask", 4'd6, 32'h8000_0000, 32'h24, 32'h0800_0000, 4'b0000);
    run_op("slt", 4'd8, 32'hFFFF_FFFF, 32'h1, 32'h1, 4'b0000);
    run_op("sltu", 4'd9, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b0100);
    run_op("op12", 4'd12, 32'h5, 32'h5, 32'h0, 4'b0100);
    @(negedge clk);
    #1 check("ops_op_count", bus.op_count, 16'd16);

    // Reset with two results in flight
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(4'd0, 32'd5, 32'd5);
    @(negedge clk);
    drive(4'd0, 32'd6, 32'd6);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1 check("mid_inflight_vld", bus.out_valid, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_out_valid", bus.out_valid, 1'b0);
    check("mid_op_count", bus.op_count, 16'd0);
    check("mid_in_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    vcount = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 if (bus.out_valid) vcount++;
    end
    check("mid_no_ghosts", vcount, 0);

    // op_count wrap after 65536 streamed transfers, order checked on the way
    do_reset();
    accepted = 0;
    seen     = 0;
    errs     = 0;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 70000 && accepted < 65536; cyc++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (bus.y !== 32'(2 * seen)) errs++;
        seen++;
      end
      drive(4'd0, 32'(accepted), 32'(accepted));
      #1 if (bus.in_ready) accepted++;
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (bus.out_valid) begin
        if (bus.y !== 32'(2 * seen)) errs++;
        seen++;
      end
    end
    check("wrap_accepted", accepted, 65536);
    check("wrap_seen", seen, 65536);
    check("wrap_order", errs, 0);
    check("wrap_zero", bus.op_count, 16'h0000);
    run_op("wrap_next", 4'd0, 32'd7, 32'd8, 32'd15, 4'b0000);
    @(negedge clk);
    #1 check("wrap_one", bus.op_count, 16'h0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
